cpu_memory_lsu: RTL

CPU_MEMORY_LSU -- requirements
Module: cpu_memory_lsu

---
 rtl/cpu_memory_lsu.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/cpu_memory_lsu.sv
// Stage-3 load/store unit: issues one memory access per instruction, stalls
// stage 3 until the access is acknowledged, then registers the stage-4
// results (push value, branch resolution, pass-through fields).
module cpu_memory_lsu #(
    parameter int                DATA_W       = 32,
    parameter int                TYPE_W       = 3,
    parameter int                IMM_W        = 16,
    parameter logic [TYPE_W-1:0] TYPE_INTEGER = TYPE_W'(1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_3a,
    input  logic [1:0]               c__branch_3a,
    input  logic [2:0]               c__to_push_3a,
    input  logic [1:0]               c__mem_3a,
    input  logic                     alu__cond_3a,
    input  logic [DATA_W-1:0]        alu__out_3a,
    input  logic [47:0]              instruction_3a,
    input  logic [DATA_W-1:0]        pc_3a,
    input  logic [TYPE_W+DATA_W-1:0] r0_3a,
    input  logic [TYPE_W+DATA_W-1:0] r1_3a,
    input  logic [10:0]              st__to_pop_3a,
    output logic                     stall_3a,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [DATA_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     valid_4a,
    output logic                     kill_4a,
    output logic [DATA_W-1:0]        branch_target_4a,
    output logic [DATA_W-1:0]        pc_4a,
    output logic [2:0]               c__to_push_4a,
    output logic [TYPE_W+DATA_W-1:0] st__to_push_4a,
    output logic [10:0]              st__to_pop_4a
);

    typedef enum logic [1:0] {
        BR_NONE     = 2'd0,
        BR_REL      = 2'd1,
        BR_REL_COND = 2'd2,
        BR_ABS      = 2'd3
    } branch_e;

    // Codes 6 and 7 are unnamed and fall into the hold (NONE) path.
    typedef enum logic [2:0] {
        PUSH_NONE = 3'd0,
        PUSH_ALU  = 3'd1,
        PUSH_IMM  = 3'd2,
        PUSH_REG0 = 3'd3,
        PUSH_REG1 = 3'd4,
        PUSH_LOAD = 3'd5
    } push_e;

    // Code 3 is unnamed and behaves as no memory operation.
    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e                  state;
    logic                    is_load;
    logic                    is_store;
    logic                    memop;
    logic                    complete;
    logic                    take_branch;
    logic [DATA_W-1:0]       imm_sext;
    logic [DATA_W-1:0]       target_next;
    logic [TYPE_W+DATA_W-1:0] push_next;

    // Instruction bits above the push immediate carry nothing this stage needs.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instruction_3a[47:TYPE_W+DATA_W];

    assign is_load  = (c__mem_3a == MEM_LOAD);
    assign is_store = (c__mem_3a == MEM_STORE);
    assign memop    = valid_3a && (is_load || is_store);

    // The request is driven in both FSM states; the stall lifts in the ack cycle.
    assign mem_req   = memop && !rst;
    assign mem_we    = mem_req && is_store;
    assign mem_addr  = alu__out_3a;
    assign mem_wdata = r0_3a[DATA_W-1:0];
    assign stall_3a  = mem_req && !mem_ack;
    assign complete  = valid_3a && !stall_3a;

    assign imm_sext = {{(DATA_W-IMM_W){instruction_3a[IMM_W-1]}}, instruction_3a[IMM_W-1:0]};

    // Branch resolution: kill decision and target for the completing instruction.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        take_branch = 1'b0;
        target_next = branch_target_4a;
        case (c__branch_3a)
            BR_REL: begin
                take_branch = 1'b1;
                target_next = pc_3a + imm_sext;
            end
            BR_REL_COND: begin
                take_branch = alu__cond_3a;
                target_next = pc_3a + imm_sext;
            end
            BR_ABS: begin
                take_branch = 1'b1;
                target_next = alu__out_3a;
            end
            default: ;
        endcase
    end

    // Value pushed to the stack; unknown or NONE codes keep the previous value.
    always_comb begin
        push_next = st__to_push_4a;
        case (c__to_push_3a)
            PUSH_ALU:  push_next = {TYPE_INTEGER, alu__out_3a};
            PUSH_IMM:  push_next = instruction_3a[TYPE_W+DATA_W-1:0];
            PUSH_REG0: push_next = r0_3a;
            PUSH_REG1: push_next = r1_3a;
            PUSH_LOAD: push_next = is_load ? {TYPE_INTEGER, mem_rdata}
                                           : {TYPE_INTEGER, {DATA_W{1'b0}}};
            default:   ;
        endcase
    end

    // Access FSM plus the registered stage-4 outputs, updated only on completion.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state            <= S_IDLE;
            valid_4a         <= 1'b0;
            kill_4a          <= 1'b0;
            branch_target_4a <= '0;
            pc_4a            <= '0;
            c__to_push_4a    <= '0;
            st__to_pop_4a    <= '0;
            st__to_push_4a   <= '0;
        end else begin
            case (state)
                S_IDLE:  if (memop && !mem_ack) state <= S_WAIT;
                S_WAIT:  if (mem_ack)           state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            valid_4a <= complete;
            kill_4a  <= complete && take_branch;

            if (complete) begin
                pc_4a            <= pc_3a;
                c__to_push_4a    <= c__to_push_3a;
                st__to_pop_4a    <= st__to_pop_3a;
                st__to_push_4a   <= push_next;
                branch_target_4a <= target_next;
            end
        end
    end

endmodule
